// File: rtl/ethmac_sim_wrapper.sv
`default_nettype none
// ============================================================================
// Module  : ethmac_sim_wrapper
// Brief   : Register-compatible Ethernet MAC stand-in with BD RAM, TX engine
//           and TX->RX loopback; models descriptors and interrupts only.
// Revision: 1.0 - initial release
// ============================================================================
module ethmac_sim_wrapper #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  output logic                ethernet_interrupt
);

  localparam logic [DATA_W-1:0] C_MODER_RST = DATA_W'(32'h0000_A000);
  localparam logic [7:0]        C_BDNUM_RST = 8'h40;
  localparam logic [7:0]        C_BDNUM_MAX = 8'h80;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND, S_DONE} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_moder;
  logic [4:0]        r_int_source;
  logic [6:0]        r_int_mask;
  logic [7:0]        r_tx_bd_num;
  logic [6:0]        r_tx_ptr;
  logic [6:0]        r_tx_cur;
  logic [7:0]        r_rx_ptr;
  logic [16:0]       r_cnt;
  logic [15:0]       r_len;
  logic              r_irq;
  logic              r_wr;
  logic [DATA_W-1:0] r_bd_ram [0:255];

  function automatic logic [DATA_W-1:0] f_merge(input logic [DATA_W-1:0]   old_v,
                                                input logic [DATA_W-1:0]   new_v,
                                                input logic [DATA_W/8-1:0] strb);
    f_merge = old_v;
    for (int b = 0; b < DATA_W/8; b++)
      if (strb[b]) f_merge[8*b +: 8] = new_v[8*b +: 8];
  endfunction

  logic       w_wr, w_rd, w_is_reg, w_sel_bd;
  logic       w_sel_moder, w_sel_isrc, w_sel_mask, w_sel_bdnum;
  logic [7:0] w_word;

  assign w_wr        = valid & (|wstrb);
  assign w_rd        = valid & ~(|wstrb);
  assign w_word      = address[9:2];
  assign w_is_reg    = (address[11:10] == 2'b00);
  assign w_sel_bd    = (address[11:10] == 2'b01);
  assign w_sel_moder = w_is_reg & (w_word == 8'h00);
  assign w_sel_isrc  = w_is_reg & (w_word == 8'h01);
  assign w_sel_mask  = w_is_reg & (w_word == 8'h02);
  assign w_sel_bdnum = w_is_reg & (w_word == 8'h08);

  logic [DATA_W-1:0] w_moder_next;
  logic [7:0]        w_tx_bd_num_next;
  logic              w_txen_fall, w_rxen_fall, w_bdnum_wr;

  assign w_moder_next     = (w_wr & w_sel_moder) ? f_merge(r_moder, wdata, wstrb) : r_moder;
  assign w_txen_fall      = r_moder[1] & ~w_moder_next[1];
  assign w_rxen_fall      = r_moder[0] & ~w_moder_next[0];
  assign w_bdnum_wr       = w_wr & w_sel_bdnum;
  assign w_tx_bd_num_next = (w_bdnum_wr && wstrb[0] && (wdata[7:0] <= C_BDNUM_MAX))
                          ? wdata[7:0] : r_tx_bd_num;

  // Descriptor views: status words of the BD being fetched, completed, and received into
  logic [DATA_W-1:0] w_tx_fetch, w_tx_done_word, w_rx_word, w_rx_new;
  logic              w_done, w_rx_go, w_rx_ok, w_rx_busy;
  logic [15:0]       w_rx_len;
  logic [7:0]        w_tx_inc, w_rx_next;
  logic [6:0]        w_tx_next;
  logic [4:0]        w_isrc_set, w_isrc_clr;

  assign w_tx_fetch     = r_bd_ram[{r_tx_ptr, 1'b0}];
  assign w_tx_done_word = r_bd_ram[{r_tx_cur, 1'b0}];
  assign w_rx_word      = r_bd_ram[{r_rx_ptr[6:0], 1'b0}];
  assign w_done         = (r_state == S_DONE);
  assign w_rx_go        = w_done & r_moder[7] & r_moder[0] & ~r_rx_ptr[7];
  assign w_rx_ok        = w_rx_go & w_rx_word[15];
  assign w_rx_busy      = w_rx_go & ~w_rx_word[15];
  assign w_rx_len       = r_len + (r_moder[13] ? 16'd4 : 16'd0);
  assign w_rx_new       = {w_rx_len, 1'b0, w_rx_word[14:9], 9'd0};
  assign w_tx_inc       = {1'b0, r_tx_cur} + 8'd1;
  assign w_tx_next      = (r_wr || (w_tx_inc == r_tx_bd_num) || !r_moder[1]) ? 7'd0 : w_tx_inc[6:0];
  assign w_rx_next      = (w_rx_word[13] || (r_rx_ptr == 8'd127)) ? r_tx_bd_num : r_rx_ptr + 8'd1;
  assign w_isrc_set     = {w_rx_busy, 1'b0, w_rx_ok & w_rx_word[14], 1'b0, w_done & r_irq};
  assign w_isrc_clr     = (w_wr & w_sel_isrc & wstrb[0]) ? wdata[4:0] : 5'd0;

  logic [DATA_W-1:0] w_rd_val;
  always_comb begin
    w_rd_val = '0;
    if (w_sel_bd)         w_rd_val = r_bd_ram[w_word];
    else if (w_sel_moder) w_rd_val = r_moder;
    else if (w_sel_isrc)  w_rd_val = DATA_W'(r_int_source);
    else if (w_sel_mask)  w_rd_val = DATA_W'(r_int_mask);
    else if (w_sel_bdnum) w_rd_val = DATA_W'(r_tx_bd_num);
  end

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      rdata        <= '0;
      ready        <= 1'b0;
      r_moder      <= C_MODER_RST;
      r_int_source <= '0;
      r_int_mask   <= '0;
      r_tx_bd_num  <= C_BDNUM_RST;
      r_tx_ptr     <= '0;
      r_tx_cur     <= '0;
      r_rx_ptr     <= C_BDNUM_RST;
      r_cnt        <= '0;
      r_len        <= '0;
      r_irq        <= 1'b0;
      r_wr         <= 1'b0;
      r_state      <= S_IDLE;
    end else begin
      ready <= valid;
      if (w_rd) rdata <= w_rd_val;
      r_moder      <= w_moder_next;
      r_tx_bd_num  <= w_tx_bd_num_next;
      r_int_source <= (r_int_source & ~w_isrc_clr) | w_isrc_set;
      if (w_wr & w_sel_mask & wstrb[0]) r_int_mask <= wdata[6:0];
      if (w_rx_ok) r_rx_ptr <= w_rx_next;
      if (w_rxen_fall | w_bdnum_wr) r_rx_ptr <= w_tx_bd_num_next;
      case (r_state)
        S_IDLE:  if (r_moder[1]) r_state <= S_FETCH;
        S_FETCH: begin
          if (w_tx_fetch[15]) begin
            r_len    <= w_tx_fetch[31:16];
            r_irq    <= w_tx_fetch[14];
            r_wr     <= w_tx_fetch[13];
            r_tx_cur <= r_tx_ptr;
            r_cnt    <= 17'd7 + {1'b0, w_tx_fetch[31:16]} + (r_moder[13] ? 17'd4 : 17'd0);
            r_state  <= S_SEND;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_SEND: begin
          if (r_cnt == 17'd0) r_state <= S_DONE;
          else                r_cnt   <= r_cnt - 17'd1;
        end
        S_DONE: begin
          r_tx_ptr <= w_tx_next;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_txen_fall) r_tx_ptr <= '0;
    end
  end

  // Engine writes come last so they override a same-cycle bus write to the same word
  always_ff @(posedge clk_i) begin
    if (w_wr & w_sel_bd) r_bd_ram[w_word] <= f_merge(r_bd_ram[w_word], wdata, wstrb);
    if (w_done)  r_bd_ram[{r_tx_cur, 1'b0}] <= {w_tx_done_word[DATA_W-1:16], 1'b0, w_tx_done_word[14:0]};
    if (w_rx_ok) r_bd_ram[{r_rx_ptr[6:0], 1'b0}] <= w_rx_new;
  end

  assign ethernet_interrupt = |({2'b00, r_int_source} & r_int_mask);

  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, address[1:0], w_tx_fetch[12:0], w_rx_word[31:16], w_rx_word[8:0]};

endmodule
`default_nettype wire

// File: tb/tb_ethmac_sim_wrapper.sv
`default_nettype none
// ============================================================================
// Module  : tb_ethmac_sim_wrapper
// Brief   : Randomized bench for ethmac_sim_wrapper against a frame-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ethmac_sim_wrapper;

  logic        clk_i   = 1'b0;
  logic        arst_i  = 1'b0;
  logic        valid   = 1'b0;
  logic [11:0] address = '0;
  logic [31:0] wdata   = '0;
  logic [3:0]  wstrb   = '0;
  logic [31:0] rdata;
  logic        ready;
  logic        ethernet_interrupt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_moder;
  logic [6:0]  m_mask;
  logic [7:0]  m_bdnum;
  logic [4:0]  m_isrc;
  logic [31:0] m_bd  [0:255];
  logic [31:0] m_bdk [0:255];

  always #5 clk_i = ~clk_i;

  ethmac_sim_wrapper #(.ADDR_W(12), .DATA_W(32)) dut (
    .clk_i              (clk_i),
    .arst_i             (arst_i),
    .valid              (valid),
    .address            (address),
    .wdata              (wdata),
    .wstrb              (wstrb),
    .rdata              (rdata),
    .ready              (ready),
    .ethernet_interrupt (ethernet_interrupt)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    merge = o;
    for (int b = 0; b < 4; b++) if (s[b]) merge[8*b +: 8] = n[8*b +: 8];
  endfunction

  task automatic bus(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s, output logic [31:0] r);
    @(negedge clk_i);
    valid = 1'b1; address = a; wdata = d; wstrb = s;
    @(negedge clk_i);
    valid = 1'b0; wstrb = '0;
    check_val("ready", {31'd0, ready}, 32'd1);
    r = rdata;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] dummy;
    bus(a, d, s, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] r;
    bus(a, 32'd0, 4'd0, r);
    check_val(tag, r, exp);
  endtask

  task automatic irq_chk(input string tag);
    check_val(tag, {31'd0, ethernet_interrupt}, {31'd0, |({2'b00, m_isrc} & m_mask)});
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    arst_i = 1'b0;
    @(negedge clk_i);
    arst_i = 1'b1;
    m_moder = 32'h0000_A000; m_mask = '0; m_bdnum = 8'h40; m_isrc = '0;
  endtask

  task automatic w1c(input logic [4:0] v, input logic [3:0] s);
    wr(12'h004, {$urandom_range(0, 255), 19'd0, v} , s);
    if (s[0]) m_isrc = m_isrc & ~v;
    rd_chk("w1c_isrc", 12'h004, {27'd0, m_isrc});
    irq_chk("w1c_irq");
  endtask

  task automatic set_mask(input logic [6:0] m);
    wr(12'h008, {25'd0, m}, 4'h1);
    m_mask = m;
    irq_chk("mask_irq");
  endtask

  // One frame from a freshly reset MAC: TX BD 0, RX BD at index TX_BD_NUM (0x40)
  task automatic run_frame(input logic [31:0] moder, input logic [31:0] txw, input logic [31:0] rxw,
                           input logic [6:0] mask, input bit clr_mid, input string tag);
    logic [31:0] exp_tx, exp_rx;
    int lat, got;
    do_reset();
    wr(12'h000, moder & ~32'h2, 4'hF);
    wr(12'h008, {25'd0, mask}, 4'h1);
    m_mask = mask;
    wr(12'h604, $urandom, 4'hF);
    wr(12'h600, rxw, 4'hF);
    wr(12'h404, $urandom, 4'hF);
    wr(12'h408, 32'd0, 4'hF);
    wr(12'h400, txw, 4'hF);
    lat = 11 + int'(txw[31:16]) + (moder[13] ? 4 : 0);
    exp_tx = txw; exp_rx = rxw; m_isrc = '0;
    if (moder[1] && txw[15]) begin
      exp_tx[15] = 1'b0;
      if (txw[14]) m_isrc[0] = 1'b1;
      if (moder[7] && moder[0]) begin
        if (rxw[15]) begin
          exp_rx = {txw[31:16] + (moder[13] ? 16'd4 : 16'd0), 1'b0, rxw[14:9], 9'd0};
          if (rxw[14]) m_isrc[2] = 1'b1;
        end else begin
          m_isrc[4] = 1'b1;
        end
      end
    end
    wr(12'h000, moder, 4'hF);
    if (clr_mid) begin
      repeat (3) @(posedge clk_i);
      wr(12'h000, moder & ~32'h2, 4'hF);
      repeat (lat) @(posedge clk_i);
    end else if (|({2'b00, m_isrc} & mask)) begin
      got = 0;
      for (int k = 1; k <= lat + 50; k++) begin
        @(posedge clk_i);
        #1;
        if (ethernet_interrupt) begin
          got = k;
          break;
        end
      end
      check_val({tag, "_latency"}, got, lat);
    end else begin
      repeat (lat + 4) @(posedge clk_i);
    end
    rd_chk({tag, "_isrc"}, 12'h004, {27'd0, m_isrc});
    rd_chk({tag, "_txbd"}, 12'h400, exp_tx);
    rd_chk({tag, "_rxbd"}, 12'h600, exp_rx);
    irq_chk({tag, "_irq"});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [11:0] a;
    logic [31:0] d, r, moder, txw, rxw;
    logic [3:0]  s;
    int          kind, idx;
    bit          crc, loop, rxen, txen, clr;

    for (int i = 0; i < 256; i++) begin m_bd[i] = '0; m_bdk[i] = '0; end

    repeat (2) @(negedge clk_i);
    check_val("rst_ready", {31'd0, ready}, 32'd0);
    check_val("rst_rdata", rdata, 32'd0);
    check_val("rst_irq", {31'd0, ethernet_interrupt}, 32'd0);
    arst_i = 1'b1;
    m_moder = 32'h0000_A000; m_mask = '0; m_bdnum = 8'h40; m_isrc = '0;
    rd_chk("rst_moder", 12'h000, 32'h0000_A000);
    rd_chk("rst_isrc",  12'h004, 32'd0);
    rd_chk("rst_mask",  12'h008, 32'd0);
    rd_chk("rst_bdnum", 12'h020, 32'h40);

    // Random register / BD RAM traffic with the engine kept disabled
    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 5);
      d    = $urandom;
      s    = 4'($urandom_range(1, 15));
      idx  = $urandom_range(0, 15);
      case (kind)
        0: a = 12'h000;
        1: a = 12'h004;
        2: a = 12'h008;
        3: a = 12'h020;
        4: a = ($urandom_range(0, 1) != 0) ? 12'(12'h010 + 4 * $urandom_range(0, 3))
                                            : 12'(12'h800 + 4 * $urandom_range(0, 511));
        default: a = 12'(12'h400 + 4 * idx);
      endcase
      if ($urandom_range(0, 1) != 0) begin
        if (kind == 0) d[1:0] = 2'b00;
        wr(a, d, s);
        case (kind)
          0: m_moder = merge(m_moder, d, s);
          2: if (s[0]) m_mask = d[6:0];
          3: if (s[0] && d[7:0] <= 8'h80) m_bdnum = d[7:0];
          5: begin
            m_bd[idx]  = merge(m_bd[idx], d, s);
            m_bdk[idx] = merge(m_bdk[idx], 32'hFFFF_FFFF, s);
          end
          default: ;
        endcase
      end else begin
        bus(a, 32'd0, 4'd0, r);
        case (kind)
          0: check_val("reg_moder", r, m_moder);
          1: check_val("reg_isrc",  r, {27'd0, m_isrc});
          2: check_val("reg_mask",  r, {25'd0, m_mask});
          3: check_val("reg_bdnum", r, {24'd0, m_bdnum});
          4: check_val("reg_unmapped", r, 32'd0);
          default: if (m_bdk[idx] != 32'd0) check_val("bd_rd", r & m_bdk[idx], m_bd[idx] & m_bdk[idx]);
        endcase
      end
    end
    irq_chk("reg_irq");

    run_frame(32'h0001_A4E3, 32'h0020_F000, 32'h0020_E000, 7'h7F, 1'b0, "loop");
    w1c(5'h01, 4'h1);
    w1c(5'h04, 4'h1);
    run_frame(32'h0001_A4E3, 32'h0020_F000, 32'h0020_E000, 7'h00, 1'b0, "masked");
    set_mask(7'h04);
    run_frame(32'h0001_A4E3, 32'h0020_F000, 32'h0000_6000, 7'h7F, 1'b0, "busy");
    run_frame(32'h0000_A403, 32'h0020_F000, 32'h0020_E000, 7'h7F, 1'b0, "noloop");
    run_frame(32'h0000_8403, 32'h0020_F000, 32'h0020_E000, 7'h7F, 1'b0, "nocrc");
    run_frame(32'h0001_A4E3, 32'h0010_D000, 32'h0020_E000, 7'h7F, 1'b1, "midclr");

    // Reset in the middle of SEND aborts the frame; the BD RAM keeps its contents
    do_reset();
    wr(12'h000, 32'h0000_A480, 4'hF);
    wr(12'h008, 32'h7F, 4'h1);
    wr(12'h408, 32'd0, 4'hF);
    wr(12'h400, 32'h0020_F000, 4'hF);
    wr(12'h600, 32'h0020_E000, 4'hF);
    wr(12'h000, 32'h0001_A4E3, 4'hF);
    repeat (12) @(posedge clk_i);
    do_reset();
    rd_chk("abort_moder", 12'h000, 32'h0000_A000);
    rd_chk("abort_isrc",  12'h004, 32'd0);
    rd_chk("abort_mask",  12'h008, 32'd0);
    rd_chk("abort_bdnum", 12'h020, 32'h40);
    repeat (60) @(posedge clk_i);
    rd_chk("abort_txbd", 12'h400, 32'h0020_F000);
    rd_chk("abort_rxbd", 12'h600, 32'h0020_E000);
    irq_chk("abort_irq");

    for (int i = 0; i < 20; i++) begin
      crc  = ($urandom_range(0, 1) != 0);
      loop = ($urandom_range(0, 3) != 0);
      rxen = ($urandom_range(0, 3) != 0);
      txen = ($urandom_range(0, 3) != 0);
      clr  = txen && ($urandom_range(0, 4) == 0);
      moder = ($urandom & 32'hFFFF_DF7C) | {18'd0, crc, 5'd0, loop, 5'd0, txen, rxen};
      txw = {16'($urandom_range(0, 40)), ($urandom_range(0, 7) != 0), 2'($urandom), 13'($urandom)};
      rxw = {16'($urandom), ($urandom_range(0, 3) != 0), 2'($urandom), 13'($urandom)};
      run_frame(moder, txw, rxw, 7'($urandom), clr, "rnd");
      w1c(5'($urandom), 4'($urandom_range(1, 15)));
      set_mask(7'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
